mac_result_collector: RTL and testbench

- Downstream consumer of the 8-bit parallel MAC product stream.
- Accepts signed products, one per beat, and sums a programmed number of them into a dot-product result.
- Queues completed results in a small FIFO and presents them to the writeback side over a valid/ready handshake.
- Sits between the MAC array column output and the output-buffer writer.

---
 rtl/mac_result_collector.sv | 163 ++++++++++++++++
 tb/tb_mac_result_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_collector
// Purpose  : Sums a programmed number of signed MAC products into one result
//            and queues results in a small FIFO behind a valid/ready handshake.
//            Optional clamping with a sticky flag: define MAC_COLLECT_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mac_result_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int PROD_WIDTH = 2*DATA_WIDTH,
  parameter int ACC_WIDTH  = DATA_WIDTH+16,
  parameter int MAX_LEN    = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = $clog2(MAX_LEN+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [PROD_WIDTH-1:0] prod_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_sat
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  state_t r_state, w_state_next;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_W-1:0]     r_cnt;
  logic [LEN_W-1:0]     r_len;

  logic [ACC_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;

  logic                 w_start_ok;
  logic                 w_last;
  logic                 w_push;
  logic                 w_pop;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] w_acc_next;

  assign w_start_ok = start && (len != '0) && (32'(len) <= MAX_LEN);
  assign w_last     = (r_cnt == r_len - LEN_W'(1));
  assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_in[PROD_WIDTH-1]}}, prod_in};
  assign w_push     = (r_state == HOLD) && (r_count != C_FULL);
  assign w_pop      = out_valid && out_ready;

`ifdef MAC_COLLECT_SAT_EN
  logic                 r_sat;
  logic                 r_sat_mem [FIFO_DEPTH];
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_clamp;

  // One guard bit: overflow when it disagrees with the result sign bit.
  assign w_sum   = {r_acc[ACC_WIDTH-1], r_acc} + {w_prod_ext[ACC_WIDTH-1], w_prod_ext};
  assign w_clamp = w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1];

  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    if (w_clamp)
      w_acc_next = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_sat_mem[i] <= 1'b0;
    end else begin
      if (r_state == IDLE && w_start_ok)
        r_sat <= 1'b0;
      else if (r_state == ACCUM && prod_valid && w_clamp)
        r_sat <= 1'b1;
      if (w_push)
        r_sat_mem[r_wr_ptr] <= r_sat;
    end
  end

  assign out_sat = r_sat_mem[r_rd_ptr];
`else
  assign w_acc_next = r_acc + w_prod_ext;
  assign out_sat    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    prod_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_next = ACCUM;
      end
      ACCUM: begin
        busy       = 1'b1;
        prod_ready = 1'b1;
        if (prod_valid && w_last) w_state_next = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (w_push) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (r_state == IDLE && w_start_ok) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= len;
    end else if (r_state == ACCUM && prod_valid) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  // Push is gated on the pre-pop count, so a full FIFO never bypasses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_acc;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_result_collector
// Purpose  : Directed self-checking bench for mac_result_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] len = '0;
  logic        busy;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [15:0] prod_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic        out_sat;

  int checks = 0;
  int errors = 0;

  logic [23:0] q_data [$];
  logic        q_sat  [$];
  logic [15:0] pbuf [0:1023];

  mac_result_collector dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_in(prod_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Record every handshake-completed result, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_sat.push_back(out_sat);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int l);
    tick();
    start = 1'b1;
    len   = 11'(l);
    tick();
    start = 1'b0;
    for (int i = 0; i < l; i++) begin
      prod_valid = 1'b1;
      prod_in    = pbuf[i];
      tick();
    end
    prod_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      tick();
      t++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_results(input int n);
    int t = 0;
    while (q_data.size() < n && t < 200) begin
      tick();
      t++;
    end
    check("result_count", q_data.size(), n);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_prod_ready", {31'd0, prod_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {8'd0, out_data}, 0);
    check("rst_out_sat", {31'd0, out_sat}, 0);
    reset = 1'b1;
    tick();

    // Basic dot product with latency check
    out_ready = 1'b1;
    pbuf[0] = 16'sd3; pbuf[1] = -16'sd2; pbuf[2] = 16'sd5; pbuf[3] = 16'sd7;
    feed(4);
    check("t1_hold_valid", {31'd0, out_valid}, 0);
    check("t1_hold_busy", {31'd0, busy}, 1);
    tick();
    check("t1_valid", {31'd0, out_valid}, 1);
    check("t1_data", {8'd0, out_data}, 32'd13);
    check("t1_busy_low", {31'd0, busy}, 0);
    tick();
    check("t1_valid_drop", {31'd0, out_valid}, 0);
    check("t1_one_result", q_data.size(), 1);

    // Single negative product, sign-extended
    q_data.delete(); q_sat.delete();
    pbuf[0] = -16'sd16256;
    feed(1);
    wait_results(1);
    check("t2_data", {8'd0, q_data[0]}, 32'h00FFC080);

    // Back-pressure: four queued, fifth held
    q_data.delete(); q_sat.delete();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pbuf[0] = 16'(k); pbuf[1] = 16'(k);
      feed(2);
      wait_idle();
    end
    check("t3_full_valid", {31'd0, out_valid}, 1);
    check("t3_head", {8'd0, out_data}, 32'd2);
    pbuf[0] = 16'd5; pbuf[1] = 16'd5;
    feed(2);
    repeat (3) tick();
    check("t3_hold_busy", {31'd0, busy}, 1);
    check("t3_hold_ready", {31'd0, prod_ready}, 0);
    out_ready = 1'b1;
    wait_results(5);
    repeat (5) tick();
    check("t3_no_dup", q_data.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < q_data.size()) check("t3_order", {8'd0, q_data[k]}, 32'(2*(k+1)));

    // Wrap or clamp on overflow, then sticky flag clears on next start
    q_data.delete(); q_sat.delete();
    for (int i = 0; i < 512; i++) pbuf[i] = 16'd16384;
    feed(512);
    wait_results(1);
`ifdef MAC_COLLECT_SAT_EN
    check("t4_data", {8'd0, q_data[0]}, 32'h007FFFFF);
    check("t4_sat", {31'd0, q_sat[0]}, 1);
`else
    check("t4_data", {8'd0, q_data[0]}, 32'h00800000);
    check("t4_sat", {31'd0, q_sat[0]}, 0);
`endif
    pbuf[0] = 16'd5;
    feed(1);
    wait_results(2);
    check("t4_next_data", {8'd0, q_data[1]}, 32'd5);
    check("t4_next_sat", {31'd0, q_sat[1]}, 0);

    // Start guards: illegal lengths ignored
    q_data.delete(); q_sat.delete();
    tick();
    start = 1'b1; len = 11'd0;
    tick();
    check("t5_len0_busy", {31'd0, busy}, 0);
    len = 11'd1025;
    tick();
    check("t5_len1025_busy", {31'd0, busy}, 0);
    start = 1'b0;
    repeat (4) tick();
    check("t5_no_output", q_data.size() + {31'd0, out_valid}, 0);

    // start during ACCUM is ignored
    start = 1'b1; len = 11'd3;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_in = 16'd1;
    tick();
    start = 1'b1; len = 11'd1; prod_in = 16'd2;
    tick();
    start = 1'b0; prod_in = 16'd3;
    check("t5_busy_mid", {31'd0, busy}, 1);
    tick();
    prod_valid = 1'b0;
    wait_results(1);
    check("t5_data", {8'd0, q_data[0]}, 32'd6);
    repeat (5) tick();
    check("t5_single", q_data.size(), 1);
    check("t5_idle", {31'd0, busy}, 0);

    // Asynchronous reset mid-ACCUM with results queued
    q_data.delete(); q_sat.delete();
    out_ready = 1'b0;
    pbuf[0] = 16'd1; feed(1); wait_idle();
    pbuf[0] = 16'd2; feed(1); wait_idle();
    check("t6_queued", {31'd0, out_valid}, 1);
    start = 1'b1; len = 11'd4;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_in = 16'd9;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    check("t6_rst_ready", {31'd0, prod_ready}, 0);
    prod_valid = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    pbuf[0] = 16'd4; pbuf[1] = 16'd4;
    feed(2);
    wait_results(1);
    check("t6_data", {8'd0, q_data[0]}, 32'd8);
    repeat (5) tick();
    check("t6_single", q_data.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
